// File: rtl/valve_scheduler_if.sv
// Sensor-side / valve-side signal bundle for valve_scheduler.
// master drives the sensor lines; slave is the scheduler.
interface valve_scheduler_if #(
    parameter int N_ZONES = 4
);
    logic [N_ZONES-1:0] req;
    logic               day;
    logic [N_ZONES-1:0] valve;
    logic               busy;
    logic [1:0]         zone_id;
    logic [5:0]         message;
    logic               done;

    modport master (
        output req, day,
        input  valve, busy, zone_id, message, done
    );

    modport slave (
        input  req, day,
        output valve, busy, zone_id, message, done
    );
endinterface

// File: rtl/valve_scheduler.sv
// Round-robin time-sharing of one water supply across N_ZONES valves,
// with a timed OPEN / GAP cycle and daylight inhibit of new grants.
module valve_scheduler #(
    parameter int          N_ZONES     = 4,
    parameter int unsigned OPEN_CYCLES = 750_000_000,
    parameter int unsigned GAP_CYCLES  = 50_000_000
) (
    input logic              Clk,
    input logic              reset,
    valve_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OPEN, GAP} state_t;

    localparam logic [31:0]        OPEN_LAST = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0]        GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [N_ZONES-1:0] ONE       = N_ZONES'(1);
    localparam logic [1:0]         LAST_ZONE = 2'(N_ZONES - 1);

    state_t      state;
    logic [31:0] cnt;
    logic [1:0]  ptr;
    logic        found;
    logic [1:0]  gnt;

    // Walk from ptr+N-1 down to ptr so the closest requester at/after ptr wins last.
    always_comb begin
        int                 idx;
        logic [N_ZONES-1:0] rot;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        rot   = '0;
        for (int i = N_ZONES - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_ZONES) idx = idx - N_ZONES;
            rot = bus.req >> idx;
            if (rot[0]) begin
                found = 1'b1;
                gnt   = 2'(idx);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= '0;
            bus.valve   <= '0;
            bus.busy    <= 1'b0;
            bus.zone_id <= '0;
            bus.message <= '0;
            bus.done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.day && found) begin
                        state       <= OPEN;
                        cnt         <= '0;
                        bus.zone_id <= gnt;
                        bus.valve   <= ONE << gnt;
                        bus.busy    <= 1'b1;
                        bus.message <= 6'd2 + {4'd0, gnt};
                        bus.done    <= (OPEN_LAST == 32'd0);
                    end else begin
                        bus.message <= {5'd0, found & bus.day};
                    end
                end
                OPEN: begin
                    // done is registered, so it is raised one edge ahead of the final cycle.
                    if (cnt == OPEN_LAST) begin
                        state       <= GAP;
                        cnt         <= '0;
                        bus.valve   <= '0;
                        bus.done    <= 1'b0;
                        bus.message <= 6'd6;
                        ptr         <= (bus.zone_id == LAST_ZONE) ? 2'd0 : bus.zone_id + 2'd1;
                    end else begin
                        cnt      <= cnt + 32'd1;
                        bus.done <= (cnt + 32'd1 == OPEN_LAST);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        bus.busy    <= 1'b0;
                        bus.message <= {5'd0, found & bus.day};
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_valve_scheduler.sv
// Directed bench for valve_scheduler with N_ZONES=4, OPEN_CYCLES=5, GAP_CYCLES=3.
module tb_valve_scheduler;
    logic Clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    valve_scheduler_if #(.N_ZONES(4)) bus ();

    valve_scheduler #(
        .N_ZONES    (4),
        .OPEN_CYCLES(5),
        .GAP_CYCLES (3)
    ) dut (
        .Clk  (Clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        bus.day = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Wait for the current grant (if any) to end and the next one to start.
    task automatic wait_grant(output int z);
        int n;
        n = 0;
        while (bus.valve != 0 && n < 40) begin tick(); n++; end
        while (bus.valve == 0 && n < 40) begin tick(); n++; end
        chk("grant_seen", {31'd0, bus.valve != 0}, 1);
        z = int'(bus.zone_id);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin tick(); n++; end
        chk("idle_seen", {31'd0, bus.busy}, 0);
    endtask

    // Invariants: at most one valve, only while OPEN, and matching zone_id.
    always @(negedge Clk) begin
        if (!reset) begin
            chk("onehot", {31'd0, $onehot0(bus.valve)}, 1);
            chk("vlv_open", {31'd0, bus.valve == 0 || (bus.message >= 2 && bus.message <= 5)}, 1);
            chk("vlv_zone", {31'd0, bus.valve == 0 || bus.valve == (4'd1 << bus.zone_id)}, 1);
        end
    end

    initial begin
        int z;
        int last;
        bus.req = '0;
        bus.day = 1'b0;

        // Reset state and single zone-1 watering cycle
        do_reset();
        chk("rst_valve", bus.valve, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_zone", bus.zone_id, 0);
        chk("rst_msg", bus.message, 0);
        chk("rst_done", bus.done, 0);
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            chk("t1_valve", bus.valve, 4'b0010);
            chk("t1_msg", bus.message, 3);
            chk("t1_busy", bus.busy, 1);
            chk("t1_done", bus.done, (k == 4) ? 1 : 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk("t1_gap_valve", bus.valve, 0);
            chk("t1_gap_msg", bus.message, 6);
            chk("t1_gap_busy", bus.busy, 1);
            chk("t1_gap_done", bus.done, 0);
            tick();
        end
        chk("t1_idle_msg", bus.message, 0);
        chk("t1_idle_busy", bus.busy, 0);

        // All zones requesting: order 0,1,2,3,0 spaced 9 cycles
        do_reset();
        bus.req = 4'b1111;
        wait_grant(z);
        chk("t2_first", z, 0);
        last = cyc;
        for (int g = 1; g <= 4; g++) begin
            wait_grant(z);
            chk("t2_order", z, g % 4);
            chk("t2_space", cyc - last, 9);
            last = cyc;
        end
        bus.req = '0;
        wait_idle();

        // Daylight inhibit, then release
        do_reset();
        bus.day = 1'b1;
        bus.req = 4'b0100;
        tick();
        tick();
        chk("t3_valve", bus.valve, 0);
        chk("t3_msg", bus.message, 1);
        chk("t3_busy", bus.busy, 0);
        bus.day = 1'b0;
        tick();
        chk("t3_grant", bus.valve, 4'b0100);
        chk("t3_msg2", bus.message, 4);
        bus.req = '0;
        wait_idle();

        // Request drop and daylight mid-watering do not shorten it
        bus.req = 4'b0010;
        tick();
        chk("t4_grant", bus.valve, 4'b0010);
        tick();
        bus.req = '0;
        bus.day = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk("t4_valve", bus.valve, 4'b0010);
            chk("t4_done", bus.done, (k == 4) ? 1 : 0);
            tick();
        end
        chk("t4_closed", bus.valve, 0);
        chk("t4_gap_msg", bus.message, 6);
        wait_idle();
        chk("t4_idle_msg", bus.message, 0);
        bus.day = 1'b0;

        // Reset in the 3rd OPEN cycle of zone 2, pointer restarts at 0
        bus.req = 4'b0100;
        tick();
        chk("t5_zone", bus.zone_id, 2);
        tick();
        tick();
        chk("t5_pre_valve", bus.valve, 4'b0100);
        reset = 1'b1;
        tick();
        chk("t5_valve", bus.valve, 0);
        chk("t5_msg", bus.message, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_busy", bus.busy, 0);
        reset   = 1'b0;
        bus.req = 4'b0101;
        tick();
        chk("t5_regrant", bus.valve, 4'b0001);
        chk("t5_rezone", bus.zone_id, 0);

        // Pointer wrap after zone 3
        bus.req = 4'b1000;
        wait_grant(z);
        chk("t6_zone3", z, 3);
        bus.req = 4'b1001;
        wait_grant(z);
        chk("t6_wrap", z, 0);
        chk("t6_valve", bus.valve, 4'b0001);
        bus.req = '0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
